// File: rtl/fgyrus_pcm_rdr.sv
// Reads stereo PCM frames out of a shared buffer and streams them as valid/ready sample pairs.
// Optional macro FGYRUS_PCM_RDR_OVERRUN_CNT_EN enables the 8-bit dropped-frame counter.
module fgyrus_pcm_rdr #(
  parameter int NUM_SAMPLES  = 128,
  parameter int MEM_RD_DELAY = 2,
  parameter int MEM_ADDR_W   = $clog2(NUM_SAMPLES) + 1
) (
  input  logic                  fgyrus_clk,
  input  logic                  fgyrus_rst,
  input  logic                  pcm_rdy,
  output logic [MEM_ADDR_W-1:0] pcm_addr,
  input  logic [31:0]           pcm_data,
  output logic                  smpl_valid,
  input  logic                  smpl_ready,
  output logic [31:0]           smpl_lchnl_data,
  output logic [31:0]           smpl_rchnl_data,
  output logic [MEM_ADDR_W-2:0] smpl_idx,
  output logic                  smpl_sof,
  output logic                  smpl_eof,
  output logic                  busy,
  output logic [7:0]            overrun_cnt,
  input  logic                  overrun_clr
);

  localparam int                 IDX_W    = MEM_ADDR_W - 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_SAMPLES - 1);
  localparam logic [2:0]         DLY_LD   = 3'(MEM_RD_DELAY + 1);

  // IDLE: no frame | RD_L/RD_R: issue left/right address | WAIT: drain read latency | PRESENT: pair offered
  typedef enum logic [2:0] {IDLE, RD_L, RD_R, WAIT, PRESENT} state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [2:0]            r_dly;
  logic [MEM_ADDR_W-1:0] r_addr;
  logic [31:0]           r_ldata, r_rdata;
  logic                  w_start, w_xfer, w_last, w_cap_l, w_cap_r;

  assign w_start = (r_state == IDLE) && pcm_rdy;
  assign w_xfer  = (r_state == PRESENT) && smpl_ready;
  assign w_last  = (r_idx == LAST_IDX);
  // r_dly counts down from the RD_L cycle; 1 marks left data arriving, 0 marks right data
  assign w_cap_l = ((r_state == RD_R) || (r_state == WAIT)) && (r_dly == 3'd1);
  assign w_cap_r = (r_state == WAIT) && (r_dly == 3'd0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (pcm_rdy) w_state_nxt = RD_L;
      RD_L:    w_state_nxt = RD_R;
      RD_R:    w_state_nxt = WAIT;
      WAIT:    if (r_dly == 3'd0) w_state_nxt = PRESENT;
      PRESENT: if (smpl_ready) w_state_nxt = w_last ? IDLE : RD_L;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge fgyrus_clk or posedge fgyrus_rst) begin
    if (fgyrus_rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_dly   <= '0;
      r_addr  <= '0;
      r_ldata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_idx  <= '0;
        r_dly  <= DLY_LD;
        r_addr <= '0;
      end else if (w_xfer && !w_last) begin
        r_idx  <= r_idx + 1'b1;
        r_dly  <= DLY_LD;
        r_addr <= {1'b0, r_idx + 1'b1};
      end else if (r_dly != 3'd0) begin
        r_dly <= r_dly - 3'd1;
      end
      if (r_state == RD_L) r_addr <= {1'b1, r_idx};
      if (w_cap_l) r_ldata <= pcm_data;
      if (w_cap_r) r_rdata <= pcm_data;
    end
  end

  assign pcm_addr        = r_addr;
  assign smpl_valid      = (r_state == PRESENT);
  assign smpl_lchnl_data = r_ldata;
  assign smpl_rchnl_data = r_rdata;
  assign smpl_idx        = r_idx;
  assign smpl_sof        = smpl_valid && (r_idx == '0);
  assign smpl_eof        = smpl_valid && w_last;
  assign busy            = (r_state != IDLE);

`ifdef FGYRUS_PCM_RDR_OVERRUN_CNT_EN
  logic [7:0] r_ovr;

  always_ff @(posedge fgyrus_clk or posedge fgyrus_rst) begin
    if (fgyrus_rst)                                         r_ovr <= '0;
    else if (overrun_clr)                                   r_ovr <= '0;
    else if (pcm_rdy && (r_state != IDLE) && r_ovr != 8'hFF) r_ovr <= r_ovr + 8'd1;
  end

  assign overrun_cnt = r_ovr;
`else
  logic w_unused_clr;
  assign w_unused_clr = overrun_clr;
  assign overrun_cnt  = '0;
`endif

endmodule
